// File: rtl/branch_ctrl_predictor_if.sv
// ----------------------------------------------------------------------------
// branch_ctrl_predictor_if
// Purpose : groups the IF lookup and ID decode/resolve signals exchanged
//           between the pipeline and the branch controller/predictor.
// Signals :
//   if_pc_i          IF-stage PC for the prediction lookup
//   if_pred_taken_o  prediction for the IF-stage instruction
//   id_valid_i       ID stage holds a real instruction
//   id_stall_i       ID stage frozen this cycle
//   id_pc_i          PC of the ID-stage instruction
//   id_pred_taken_i  prediction carried down the IF/ID register
//   opcode_i         ID-stage opcode
//   equal_i          register-compare result from ID
//   all_ctrl_o       9-bit control bundle
//   mispredict_o     ID-stage branch mispredicted
//   redirect_taken_o on mispredict: 1 = fetch target, 0 = fetch id_pc_i+4
// Modports: master = pipeline side, slave = controller side.
// ----------------------------------------------------------------------------
interface branch_ctrl_predictor_if #(
    parameter int unsigned OP_WIDTH = 6,
    parameter int unsigned PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] if_pc_i;
    logic                if_pred_taken_o;
    logic                id_valid_i;
    logic                id_stall_i;
    logic [PC_WIDTH-1:0] id_pc_i;
    logic                id_pred_taken_i;
    logic [OP_WIDTH-1:0] opcode_i;
    logic                equal_i;
    logic [8:0]          all_ctrl_o;
    logic                mispredict_o;
    logic                redirect_taken_o;

    modport master (
        output if_pc_i, id_valid_i, id_stall_i, id_pc_i, id_pred_taken_i,
               opcode_i, equal_i,
        input  if_pred_taken_o, all_ctrl_o, mispredict_o, redirect_taken_o
    );

    modport slave (
        input  if_pc_i, id_valid_i, id_stall_i, id_pc_i, id_pred_taken_i,
               opcode_i, equal_i,
        output if_pred_taken_o, all_ctrl_o, mispredict_o, redirect_taken_o
    );
endinterface

// File: rtl/branch_ctrl_predictor.sv
// ----------------------------------------------------------------------------
// branch_ctrl_predictor
// Purpose : ID-stage control decode (with BNE and bubble handling), branch
//           resolution / mispredict detection, an optional bimodal predictor
//           table (read in IF, trained in ID) and saturating branch /
//           mispredict statistics.
// Ports   :
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       IF lookup + ID decode/resolve signals, see interface
//   branch_cnt_o      resolved branches (registered, saturating)
//   mispredict_cnt_o  mispredicted branches (registered, saturating)
// ----------------------------------------------------------------------------
module branch_ctrl_predictor #(
    parameter int unsigned OP_WIDTH     = 6,
    parameter int unsigned PC_WIDTH     = 32,
    parameter int unsigned BHT_ENTRIES  = 16,
    parameter int unsigned CTR_WIDTH    = 2,
    parameter int unsigned PREDICT_MODE = 1,
    parameter int unsigned STAT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    branch_ctrl_predictor_if.slave    bus,
    output logic [STAT_WIDTH-1:0]     branch_cnt_o,
    output logic [STAT_WIDTH-1:0]     mispredict_cnt_o
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [OP_WIDTH-1:0] OP_R    = OP_WIDTH'(6'b000000);
    localparam logic [OP_WIDTH-1:0] OP_LW   = OP_WIDTH'(6'b100011);
    localparam logic [OP_WIDTH-1:0] OP_SW   = OP_WIDTH'(6'b101011);
    localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(6'b001000);
    localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(6'b000100);
    localparam logic [OP_WIDTH-1:0] OP_BNE  = OP_WIDTH'(6'b000101);

    // Legacy control encodings, kept bit-exact with the original core.
    localparam logic [8:0] CTRL_R     = 9'b110000101;
    localparam logic [8:0] CTRL_LW    = 9'b000110000;
    localparam logic [8:0] CTRL_SW    = 9'b001010000;
    localparam logic [8:0] CTRL_ADDI  = 9'b100010000;
    localparam logic [8:0] CTRL_BR    = 9'b000000010;
    localparam logic [8:0] CTRL_OTHER = 9'b000000110;

    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((2 ** (CTR_WIDTH - 1)) - 1);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = {STAT_WIDTH{1'b1}};

    logic [8:0] w_ctrl;
    logic       w_is_branch;
    logic       w_taken;
    logic       w_resolved;
    logic       w_mispredict;

    logic [STAT_WIDTH-1:0] r_branch_cnt;
    logic [STAT_WIDTH-1:0] r_mispredict_cnt;

    // Opcode decode; a bubble clears the bundle and hides any branch.
    always_comb begin
        w_ctrl      = CTRL_OTHER;
        w_is_branch = 1'b0;
        case (bus.opcode_i)
            OP_R:    w_ctrl = CTRL_R;
            OP_LW:   w_ctrl = CTRL_LW;
            OP_SW:   w_ctrl = CTRL_SW;
            OP_ADDI: w_ctrl = CTRL_ADDI;
            OP_BEQ, OP_BNE: begin
                w_ctrl      = CTRL_BR;
                w_is_branch = 1'b1;
            end
            default: w_ctrl = CTRL_OTHER;
        endcase
        if (!bus.id_valid_i) begin
            w_ctrl      = 9'b0;
            w_is_branch = 1'b0;
        end
    end

    // Branch outcome and mispredict; a stalled branch is not yet resolved.
    always_comb begin
        w_taken      = (bus.opcode_i == OP_BEQ) ? bus.equal_i : ~bus.equal_i;
        w_resolved   = w_is_branch & ~bus.id_stall_i;
        w_mispredict = w_resolved & (w_taken ^ bus.id_pred_taken_i);
    end

    assign bus.all_ctrl_o       = w_ctrl;
    assign bus.mispredict_o     = w_mispredict;
    assign bus.redirect_taken_o = w_is_branch & w_taken;

    generate
        if (PREDICT_MODE == 1) begin : g_bimodal
            logic [CTR_WIDTH-1:0] r_bht [BHT_ENTRIES];
            logic [IDX_W-1:0]     w_rd_idx;
            logic [IDX_W-1:0]     w_wr_idx;
            logic [CTR_WIDTH-1:0] w_wr_ctr;
            logic [CTR_WIDTH-1:0] w_ctr_next;
            logic                 w_unused_pc;

            assign w_rd_idx    = bus.if_pc_i[IDX_W+1:2];
            assign w_wr_idx    = bus.id_pc_i[IDX_W+1:2];
            assign w_wr_ctr    = r_bht[w_wr_idx];
            assign w_unused_pc = ^{bus.if_pc_i[PC_WIDTH-1:IDX_W+2], bus.if_pc_i[1:0],
                                   bus.id_pc_i[PC_WIDTH-1:IDX_W+2], bus.id_pc_i[1:0]};

            // Saturating up/down step of the counter being trained.
            always_comb begin
                w_ctr_next = w_wr_ctr;
                if (w_taken) begin
                    if (w_wr_ctr != CTR_MAX) w_ctr_next = w_wr_ctr + CTR_WIDTH'(1);
                end else begin
                    if (w_wr_ctr != '0) w_ctr_next = w_wr_ctr - CTR_WIDTH'(1);
                end
            end

            // Single write port; no read bypass, IF sees the old value.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < BHT_ENTRIES; i++) begin
                        r_bht[i] <= CTR_INIT;
                    end
                end else if (w_resolved) begin
                    r_bht[w_wr_idx] <= w_ctr_next;
                end
            end

            assign bus.if_pred_taken_o = r_bht[w_rd_idx][CTR_WIDTH-1];
        end else begin : g_static
            logic w_unused_pc;
            assign w_unused_pc         = ^{bus.if_pc_i, bus.id_pc_i};
            assign bus.if_pred_taken_o = 1'b0;
        end
    endgenerate

    // Saturating statistics; they stop at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_resolved) begin
            if (r_branch_cnt != STAT_MAX) r_branch_cnt <= r_branch_cnt + STAT_WIDTH'(1);
            if (w_mispredict && (r_mispredict_cnt != STAT_MAX))
                r_mispredict_cnt <= r_mispredict_cnt + STAT_WIDTH'(1);
        end
    end

    assign branch_cnt_o     = r_branch_cnt;
    assign mispredict_cnt_o = r_mispredict_cnt;

endmodule

// File: tb/tb_branch_ctrl_predictor.sv
module tb_branch_ctrl_predictor;

    logic clk;
    logic rst_n;

    branch_ctrl_predictor_if #(.OP_WIDTH(6), .PC_WIDTH(32)) d_if ();
    branch_ctrl_predictor_if #(.OP_WIDTH(6), .PC_WIDTH(32)) s_if ();

    logic [15:0] d_bcnt, d_mcnt;
    logic [3:0]  s_bcnt, s_mcnt;

    int n_tests;
    int n_fail;
    int e_b;
    int e_m;

    branch_ctrl_predictor u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (d_if.slave),
        .branch_cnt_o     (d_bcnt),
        .mispredict_cnt_o (d_mcnt)
    );

    branch_ctrl_predictor #(
        .STAT_WIDTH   (4),
        .PREDICT_MODE (0)
    ) u_sat (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (s_if.slave),
        .branch_cnt_o     (s_bcnt),
        .mispredict_cnt_o (s_mcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_d(input logic [5:0] op, input logic [31:0] pc, input logic valid,
                         input logic stall, input logic pred, input logic eq);
        d_if.opcode_i        = op;
        d_if.id_pc_i         = pc;
        d_if.id_valid_i      = valid;
        d_if.id_stall_i      = stall;
        d_if.id_pred_taken_i = pred;
        d_if.equal_i         = eq;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_d(6'b000000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        d_if.if_pc_i = 32'h0;
        s_if.if_pc_i = 32'h0;
        s_if.opcode_i = 6'b000000; s_if.id_pc_i = 32'h0; s_if.id_valid_i = 1'b0;
        s_if.id_stall_i = 1'b0; s_if.id_pred_taken_i = 1'b0; s_if.equal_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (d_bcnt !== 16'd0 || d_mcnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stats got b=%0d m=%0d exp 0/0", d_bcnt, d_mcnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d_if.if_pc_i = 32'(i) << 2;
            #1;
            n_tests++;
            if (d_if.if_pred_taken_o !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_pred idx=%0d got=%b exp=0", i, d_if.if_pred_taken_o);
            end
        end
        n_tests++;
        if (s_bcnt !== 4'd0 || s_mcnt !== 4'd0 || s_if.if_pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_sat got b=%0d m=%0d p=%b exp 0/0/0", s_bcnt, s_mcnt,
                     s_if.if_pred_taken_o);
        end
        e_b = 0;
        e_m = 0;
    endtask

    task automatic test_decode();
        logic [5:0] ops [7];
        logic [8:0] exp [7];
        ops[0] = 6'b000000; exp[0] = 9'b110000101;
        ops[1] = 6'b100011; exp[1] = 9'b000110000;
        ops[2] = 6'b101011; exp[2] = 9'b001010000;
        ops[3] = 6'b001000; exp[3] = 9'b100010000;
        ops[4] = 6'b000100; exp[4] = 9'b000000010;
        ops[5] = 6'b000101; exp[5] = 9'b000000010;
        ops[6] = 6'b111111; exp[6] = 9'b000000110;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            set_d(ops[i], 32'h40, 1'b1, 1'b1, 1'b0, 1'b1);
            #1;
            n_tests++;
            if (d_if.all_ctrl_o !== exp[i]) begin
                n_fail++;
                $display("FAIL decode op=%b got=%b exp=%b", ops[i], d_if.all_ctrl_o, exp[i]);
            end
            d_if.id_valid_i = 1'b0;
            #1;
            n_tests++;
            if (d_if.all_ctrl_o !== 9'b0) begin
                n_fail++;
                $display("FAIL decode_bubble op=%b got=%b exp=0", ops[i], d_if.all_ctrl_o);
            end
        end
        // Bubble carrying a BEQ opcode must not resolve.
        @(negedge clk);
        set_d(6'b000100, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (d_if.mispredict_o !== 1'b0 || d_if.redirect_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bubble_branch got mis=%b red=%b exp 0/0", d_if.mispredict_o,
                     d_if.redirect_taken_o);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (d_bcnt !== 16'd0 || d_mcnt !== 16'd0 || d_if.if_pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_no_count got b=%0d m=%0d p=%b exp 0/0/0", d_bcnt, d_mcnt,
                     d_if.if_pred_taken_o);
        end
    endtask

    task automatic test_training();
        // Per step: equal_i, id_pred_taken_i, expected mispredict, prediction after.
        logic st_eq [10];
        logic st_pr [10];
        logic st_mis [10];
        logic st_after [10];
        logic prev_pred;
        st_eq[0] = 1; st_pr[0] = 0; st_mis[0] = 1; st_after[0] = 1; // 01 -> 10
        st_eq[1] = 1; st_pr[1] = 0; st_mis[1] = 1; st_after[1] = 1; // 10 -> 11
        for (int k = 2; k < 8; k++) begin
            st_eq[k] = 1; st_pr[k] = 1; st_mis[k] = 0; st_after[k] = 1; // stays 11
        end
        st_eq[8] = 0; st_pr[8] = 1; st_mis[8] = 1; st_after[8] = 1; // 11 -> 10
        st_eq[9] = 0; st_pr[9] = 1; st_mis[9] = 1; st_after[9] = 0; // 10 -> 01
        prev_pred = 1'b0;
        d_if.if_pc_i = 32'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            set_d(6'b000100, 32'h40, 1'b1, 1'b0, st_pr[k], st_eq[k]);
            #1;
            n_tests++;
            if (d_if.mispredict_o !== st_mis[k] || d_if.redirect_taken_o !== st_eq[k]) begin
                n_fail++;
                $display("FAIL train_resolve step=%0d got mis=%b red=%b exp %b/%b", k,
                         d_if.mispredict_o, d_if.redirect_taken_o, st_mis[k], st_eq[k]);
            end
            n_tests++;
            if (d_if.if_pred_taken_o !== prev_pred) begin
                n_fail++;
                $display("FAIL train_old_read step=%0d got=%b exp=%b", k,
                         d_if.if_pred_taken_o, prev_pred);
            end
            @(posedge clk);
            #1;
            e_b++;
            if (st_mis[k]) e_m++;
            n_tests++;
            if (d_if.if_pred_taken_o !== st_after[k] || d_bcnt !== 16'(e_b) ||
                d_mcnt !== 16'(e_m)) begin
                n_fail++;
                $display("FAIL train_update step=%0d got p=%b b=%0d m=%0d exp %b/%0d/%0d", k,
                         d_if.if_pred_taken_o, d_bcnt, d_mcnt, st_after[k], e_b, e_m);
            end
            prev_pred = st_after[k];
        end
    endtask

    task automatic test_bne();
        // BNE not taken while predicted taken: mispredict, redirect to pc+4.
        @(negedge clk);
        set_d(6'b000101, 32'h44, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        n_tests++;
        if (d_if.mispredict_o !== 1'b1 || d_if.redirect_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bne_nt got mis=%b red=%b exp 1/0", d_if.mispredict_o,
                     d_if.redirect_taken_o);
        end
        @(posedge clk);
        #1;
        e_b++; e_m++;
        n_tests++;
        if (d_mcnt !== 16'(e_m) || d_bcnt !== 16'(e_b)) begin
            n_fail++;
            $display("FAIL bne_cnt got b=%0d m=%0d exp %0d/%0d", d_bcnt, d_mcnt, e_b, e_m);
        end
        // BNE taken, predicted taken: no mispredict.
        @(negedge clk);
        set_d(6'b000101, 32'h44, 1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (d_if.mispredict_o !== 1'b0 || d_if.redirect_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bne_t got mis=%b red=%b exp 0/1", d_if.mispredict_o,
                     d_if.redirect_taken_o);
        end
        @(posedge clk);
        #1;
        e_b++;
        n_tests++;
        if (d_mcnt !== 16'(e_m) || d_bcnt !== 16'(e_b)) begin
            n_fail++;
            $display("FAIL bne_t_cnt got b=%0d m=%0d exp %0d/%0d", d_bcnt, d_mcnt, e_b, e_m);
        end
    endtask

    task automatic test_stall();
        d_if.if_pc_i = 32'h8;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_d(6'b000100, 32'h48, 1'b1, 1'b1, 1'b0, 1'b1);
            #1;
            n_tests++;
            if (d_if.mispredict_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_mis cyc=%0d got=%b exp=0", c, d_if.mispredict_o);
            end
            @(posedge clk);
            #1;
            n_tests++;
            if (d_bcnt !== 16'(e_b) || d_mcnt !== 16'(e_m) || d_if.if_pred_taken_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got b=%0d m=%0d p=%b exp %0d/%0d/0", c,
                         d_bcnt, d_mcnt, d_if.if_pred_taken_o, e_b, e_m);
            end
        end
        @(negedge clk);
        d_if.id_stall_i = 1'b0;
        #1;
        n_tests++;
        if (d_if.mispredict_o !== 1'b1 || d_if.redirect_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release got mis=%b red=%b exp 1/1", d_if.mispredict_o,
                     d_if.redirect_taken_o);
        end
        @(posedge clk);
        #1;
        e_b++; e_m++;
        @(negedge clk);
        d_if.id_valid_i = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (d_bcnt !== 16'(e_b) || d_mcnt !== 16'(e_m) || d_if.if_pred_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_once got b=%0d m=%0d p=%b exp %0d/%0d/1", d_bcnt, d_mcnt,
                     d_if.if_pred_taken_o, e_b, e_m);
        end
    endtask

    task automatic test_saturation();
        int exp_c;
        s_if.if_pc_i = 32'h40;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s_if.opcode_i = 6'b000100; s_if.id_pc_i = 32'h40; s_if.id_valid_i = 1'b1;
            s_if.id_stall_i = 1'b0; s_if.id_pred_taken_i = 1'b0; s_if.equal_i = 1'b1;
            #1;
            n_tests++;
            if (s_if.mispredict_o !== 1'b1 || s_if.if_pred_taken_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_comb k=%0d got mis=%b p=%b exp 1/0", k, s_if.mispredict_o,
                         s_if.if_pred_taken_o);
            end
            @(posedge clk);
            #1;
            exp_c = (k + 1 > 15) ? 15 : k + 1;
            n_tests++;
            if (s_bcnt !== 4'(exp_c) || s_mcnt !== 4'(exp_c) || s_if.if_pred_taken_o !== 1'b0) begin
                n_fail++;
                $display("FAIL sat_cnt k=%0d got b=%0d m=%0d p=%b exp %0d/%0d/0", k, s_bcnt,
                         s_mcnt, s_if.if_pred_taken_o, exp_c, exp_c);
            end
        end
        @(negedge clk);
        s_if.id_valid_i = 1'b0;
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        d_if.id_valid_i = 1'b0;
        d_if.if_pc_i    = 32'h8;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (d_bcnt !== 16'd0 || d_mcnt !== 16'd0 || d_if.if_pred_taken_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset got b=%0d m=%0d p=%b exp 0/0/0", d_bcnt, d_mcnt,
                     d_if.if_pred_taken_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_d(6'b000100, 32'h48, 1'b1, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        n_tests++;
        if (d_bcnt !== 16'd1 || d_mcnt !== 16'd1 || d_if.if_pred_taken_o !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset got b=%0d m=%0d p=%b exp 1/1/1", d_bcnt, d_mcnt,
                     d_if.if_pred_taken_o);
        end
        @(negedge clk);
        d_if.id_valid_i = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        e_b     = 0;
        e_m     = 0;
        test_reset();
        test_decode();
        test_training();
        test_bne();
        test_stall();
        test_saturation();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
